uart_ram_loader: RTL and testbench

//  Boot/upload sequencer between the UART receive FIFO and the data RAM write port.
//  - On a start pulse (CPU store to the loader control address, decoded by the I/O

---
 rtl/uart_ram_loader_pkg.sv | 23 ++
 rtl/uart_ram_loader_byte_timeout.sv | 29 ++
 rtl/uart_ram_loader.sv | 141 ++++++++++++++
 tb/tb_uart_ram_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ram_loader_pkg.sv
// Shared definitions for the UART boot/upload loader: FSM states, status codes
// and the default response bytes.
package uart_ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_RESP
    } state_t;

    localparam logic [1:0] STATUS_NONE = 2'b00;
    localparam logic [1:0] STATUS_OK   = 2'b01;
    localparam logic [1:0] STATUS_CSUM = 2'b10;
    localparam logic [1:0] STATUS_TMO  = 2'b11;

    localparam logic [7:0] DEF_ACK = 8'h06;
    localparam logic [7:0] DEF_NAK = 8'h15;

endpackage

// File: rtl/uart_ram_loader_byte_timeout.sv
// Clearable idle counter; tc is high once LIMIT-1 enabled cycles have elapsed
// since the last clear, and the count saturates there.
module byte_timeout #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Boot/upload sequencer: takes a counted, XOR-checked frame from the UART rx FIFO,
// writes it into data RAM as little-endian words, and answers ACK/NAK on UART tx.
module uart_ram_loader
    import uart_ram_loader_pkg::*;
#(
    parameter int         AW      = 12,
    parameter int         TIMEOUT = 50000,
    parameter logic [7:0] ACK_B   = DEF_ACK,
    parameter logic [7:0] NAK_B   = DEF_NAK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [7:0]    w_data,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          cpu_hold,
    output logic [1:0]    status
);

    state_t          state, state_next;
    logic [AW-3:0]   wptr;
    logic [15:0]     remaining;
    logic [7:0]      cnt_lo;
    logic [7:0]      xor_acc;
    logic [7:0]      resp;
    logic [1:0]      bidx;
    logic [31:0]     word;
    logic [1:0]      status_q;

    logic            consume_st;
    logic            pop;
    logic            tmo_tc;
    logic            timed_out;
    logic            unused_base;

    assign unused_base = ^base_addr[1:0];

    assign consume_st = (state == ST_HDR0) || (state == ST_HDR1) ||
                        (state == ST_DATA) || (state == ST_CHK);
    assign pop        = consume_st && !rx_empty;
    assign timed_out  = consume_st && rx_empty && tmo_tc;

    assign rd_uart  = pop;
    assign wr_uart  = (state == ST_RESP) && !tx_full;
    assign w_data   = resp;
    assign cpu_hold = (state != ST_IDLE);
    assign status   = status_q;

    // While a session owns the port the CPU write enable is masked entirely.
    assign ram_we    = cpu_hold ? (state == ST_WRITE) : cpu_we;
    assign ram_addr  = cpu_hold ? {wptr, 2'b00} : cpu_addr;
    assign ram_wdata = cpu_hold ? word : cpu_wdata;

    byte_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .reset(reset),
        .clr  (pop || (state == ST_IDLE)),
        .en   (consume_st && rx_empty),
        .tc   (tmo_tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_HDR0;
            ST_HDR0:  if (pop) state_next = ST_HDR1;
            ST_HDR1:  if (pop) state_next = ({r_data, cnt_lo} == 16'd0) ? ST_CHK : ST_DATA;
            ST_DATA:  if (pop && bidx == 2'd3) state_next = ST_WRITE;
            ST_WRITE: state_next = (remaining == 16'd1) ? ST_CHK : ST_DATA;
            ST_CHK:   if (pop) state_next = ST_RESP;
            ST_RESP:  if (!tx_full) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (timed_out) state_next = ST_RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            remaining <= '0;
            cnt_lo    <= '0;
            xor_acc   <= '0;
            resp      <= '0;
            bidx      <= '0;
            word      <= '0;
            status_q  <= STATUS_NONE;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        wptr      <= base_addr[AW-1:2];
                        remaining <= '0;
                        cnt_lo    <= '0;
                        xor_acc   <= '0;
                        bidx      <= '0;
                    end
                end
                ST_HDR0: if (pop) cnt_lo <= r_data;
                ST_HDR1: if (pop) remaining <= {r_data, cnt_lo};
                ST_DATA: begin
                    if (pop) begin
                        word[{bidx, 3'b000} +: 8] <= r_data;
                        bidx                      <= bidx + 2'd1;
                    end
                end
                ST_WRITE: begin
                    wptr      <= wptr + 1'b1;
                    remaining <= remaining - 16'd1;
                end
                ST_CHK: begin
                    if (pop) begin
                        resp     <= (r_data == xor_acc) ? ACK_B : NAK_B;
                        status_q <= (r_data == xor_acc) ? STATUS_OK : STATUS_CSUM;
                    end
                end
                default: ;
            endcase
            if (pop) xor_acc <= xor_acc ^ r_data;
            if (timed_out) begin
                resp     <= NAK_B;
                status_q <= STATUS_TMO;
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: directed frame table, reset/back-pressure/timeout
// sequences, and randomized frames checked against a frame-level model.
module tb_uart_ram_loader;

    localparam int AW  = 12;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          rx_empty = 1'b1;
    logic [7:0]    r_data = '0;
    logic          rd_uart;
    logic          tx_full = 1'b0;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          cpu_hold;
    logic [1:0]    status;

    uart_ram_loader #(
        .AW(AW),
        .TIMEOUT(TMO),
        .ACK_B(8'h06),
        .NAK_B(8'h15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_hold(cpu_hold), .status(status)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  tx_log[$];
    logic [43:0] wr_log[$];
    logic [43:0] exp_wr[$];

    int cyc = 0, last_pop_cyc = 0, push_cyc = 0;
    bit rx_gate = 1'b1;
    int gap_pct = 0;
    bit tx_rand = 1'b0;

    logic          s_rd, s_we, s_wr, s_hold;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wd;
    logic [7:0]    s_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic upd_rx();
        rx_empty = !(rx_gate && rx_q.size() > 0);
        r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    endtask

    // Inputs only change just after posedge, so negedge values are what the edge sees.
    always @(negedge clk) begin
        s_rd = rd_uart; s_we = ram_we; s_addr = ram_addr; s_wd = ram_wdata;
        s_wr = wr_uart; s_wdata = w_data; s_hold = cpu_hold;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            if (s_rd && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                last_pop_cyc = cyc;
            end
            if (s_hold && s_we) wr_log.push_back({s_addr, s_wd});
            if (s_wr) begin
                tx_log.push_back(s_wdata);
                push_cyc = cyc;
            end
        end
        if (gap_pct > 0) rx_gate = ($urandom_range(0, 99) >= gap_pct);
        if (tx_rand) tx_full = ($urandom_range(0, 3) == 0);
        upd_rx();
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int txhold, input bit restart);
        int n;
        int bad;
        wr_log.delete();
        tx_log.delete();
        foreach (frame_q[i]) rx_q.push_back(frame_q[i]);
        if (restart) rx_gate = 1'b0;
        if (txhold > 0) tx_full = 1'b1;
        upd_rx();
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_rise", cpu_hold, 1);
        if (restart) begin
            tick(3);
            start = 1'b1;
            base_addr = base ^ 12'h800;
            tick();
            start = 1'b0;
            rx_gate = 1'b1;
            upd_rx();
        end
        if (txhold > 0) begin
            n = 0;
            while (rx_q.size() > 0 && n < 2000) begin tick(); n++; end
            bad = 0;
            for (int c = 0; c < txhold; c++) begin
                if (wr_uart !== 1'b0 || cpu_hold !== 1'b1) bad++;
                tick();
            end
            check("txfull_stall_bad_cycles", bad, 0);
            check("txfull_no_push", tx_log.size(), 0);
            tx_full = 1'b0;
            tick();
            check("push_after_txfull", tx_log.size(), 1);
            check("hold_drop_after_push", cpu_hold, 0);
        end
        n = 0;
        while (cpu_hold && n < 4000) begin tick(); n++; end
        check("session_end", cpu_hold, 0);
    endtask

    task automatic compare_result(input logic [1:0] st, input logic [7:0] rsp);
        check("resp_count", tx_log.size(), 1);
        check("resp_byte", (tx_log.size() > 0) ? 64'(tx_log[0]) : 64'hDEAD, 64'(rsp));
        check("status", status, st);
        check("write_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            check($sformatf("write%0d", i), (i < wr_log.size()) ? 64'(wr_log[i]) : '1, 64'(exp_wr[i]));
    endtask

    // Frame-level reference: parses whatever bytes were actually sent.
    task automatic model(input logic [AW-1:0] base, output logic [1:0] st, output logic [7:0] rsp);
        int len;
        int cnt;
        int need;
        int nfull;
        int a;
        logic [7:0]  x;
        logic [31:0] w;
        len = frame_q.size();
        exp_wr.delete();
        st  = 2'b11;
        rsp = 8'h15;
        if (len >= 2) begin
            cnt   = int'(frame_q[0]) + 256 * int'(frame_q[1]);
            need  = 3 + 4 * cnt;
            nfull = (len >= need) ? cnt : (len - 2) / 4;
            for (int i = 0; i < nfull; i++) begin
                w = {frame_q[2+4*i+3], frame_q[2+4*i+2], frame_q[2+4*i+1], frame_q[2+4*i]};
                a = ((int'(base) / 4 + i) % (1 << (AW - 2))) * 4;
                exp_wr.push_back({a[AW-1:0], w});
            end
            if (len >= need) begin
                x = 8'h00;
                for (int j = 0; j < need - 1; j++) x ^= frame_q[j];
                st  = (x == frame_q[need-1]) ? 2'b01 : 2'b10;
                rsp = (x == frame_q[need-1]) ? 8'h06 : 8'h15;
            end
        end
    endtask

    typedef struct {
        logic [95:0]   bytes;
        int            len;
        logic [AW-1:0] base;
        int            txhold;
        bit            restart;
        logic [1:0]    st;
        logic [7:0]    resp;
        int            nwr;
        logic [43:0]   wr0;
        logic [43:0]   wr1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0] mst;
        logic [7:0] mrsp;
        int nw;
        logic [7:0] b;
        logic [7:0] x;

        vecs[0] = '{96'h02_00_11_22_33_44_55_66_77_88_8A, 11, 12'h100, 0, 1'b0, 2'b01, 8'h06, 2,
                    {12'h100, 32'h44332211}, {12'h104, 32'h88776655}};
        vecs[1] = '{96'h02_00_11_22_33_44_55_66_77_88_8B, 11, 12'h100, 0, 1'b0, 2'b10, 8'h15, 2,
                    {12'h100, 32'h44332211}, {12'h104, 32'h88776655}};
        vecs[2] = '{96'h00_00_00, 3, 12'h300, 0, 1'b1, 2'b01, 8'h06, 0, 44'h0, 44'h0};
        vecs[3] = '{96'h02_00_01_02_03_04_05_06_07_08_0A, 11, 12'hFFE, 0, 1'b0, 2'b01, 8'h06, 2,
                    {12'hFFC, 32'h04030201}, {12'h000, 32'h08070605}};
        vecs[4] = '{96'h01_00_DE_AD_BE_EF_23, 7, 12'h200, 20, 1'b0, 2'b01, 8'h06, 1,
                    {12'h200, 32'hEFBEADDE}, 44'h0};
        vecs[5] = '{96'h02_00_11_22_33, 5, 12'h100, 0, 1'b0, 2'b11, 8'h15, 0, 44'h0, 44'h0};

        #1;
        check("rst_hold", cpu_hold, 0);
        check("rst_status", status, 0);
        check("rst_rd", rd_uart, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_wdata", w_data, 0);
        tick(2);
        reset = 1'b1;
        tick();

        // Reset asserted while the loader is mid-word.
        frame_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        foreach (frame_q[i]) rx_q.push_back(frame_q[i]);
        upd_rx();
        base_addr = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        check("middata_hold", cpu_hold, 1);
        cpu_we = 1'b1; cpu_addr = 12'h55C; cpu_wdata = 32'hCAFEF00D;
        reset = 1'b0;
        #1;
        check("midrst_hold", cpu_hold, 0);
        check("midrst_status", status, 0);
        check("midrst_rd", rd_uart, 0);
        check("midrst_wr", wr_uart, 0);
        check("midrst_wdata", w_data, 0);
        check("midrst_ram", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'h55C, 32'hCAFEF00D});
        tick();
        rx_q.delete();
        upd_rx();
        reset = 1'b1;
        cpu_addr = 12'h0A8; cpu_wdata = 32'h12345678;
        #1;
        check("postrst_ram", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'h0A8, 32'h12345678});
        tick();

        // Directed frames; cpu_we stays high to prove it is blocked during hold.
        for (int v = 0; v < 6; v++) begin
            frame_q.delete();
            for (int i = 0; i < vecs[v].len; i++)
                frame_q.push_back(vecs[v].bytes[8*(vecs[v].len-1-i) +: 8]);
            exp_wr.delete();
            if (vecs[v].nwr > 0) exp_wr.push_back(vecs[v].wr0);
            if (vecs[v].nwr > 1) exp_wr.push_back(vecs[v].wr1);
            run_frame(vecs[v].base, vecs[v].txhold, vecs[v].restart);
            compare_result(vecs[v].st, vecs[v].resp);
            if (vecs[v].restart) begin
                tick(3);
                check("start_while_busy_ignored", cpu_hold, 0);
            end
            if (vecs[v].st == 2'b11)
                check("timeout_cycles", push_cyc - last_pop_cyc, TMO + 1);
            tick(2);
        end
        tick(10);
        check("status_held", status, 2'b11);
        cpu_we = 1'b0;

        // Randomized frames with rx gaps and tx back-pressure.
        gap_pct = 25;
        tx_rand = 1'b1;
        for (int s = 0; s < 10; s++) begin
            frame_q.delete();
            nw = $urandom_range(0, 5);
            frame_q.push_back(8'(nw));
            frame_q.push_back(8'h00);
            for (int i = 0; i < 4 * nw; i++) begin
                b = 8'($urandom);
                frame_q.push_back(b);
            end
            x = 8'h00;
            foreach (frame_q[i]) x ^= frame_q[i];
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
            if ($urandom_range(0, 6) == 0)
                while (frame_q.size() > $urandom_range(0, 4 * nw + 2)) void'(frame_q.pop_back());
            base_addr = 12'($urandom);
            model(base_addr, mst, mrsp);
            run_frame(base_addr, 0, 1'b0);
            compare_result(mst, mrsp);
            tick(2);
        end
        gap_pct = 0;
        tx_rand = 1'b0;
        tx_full = 1'b0;
        rx_gate = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
